// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM states and the iteration count.
package muldiv_pkg;

   localparam int ITER_COUNT = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // Signed ops are the even encodings; bit 1 selects divide.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of a pair of words.
// wide_i=0: hi and lo are negated independently (operand abs, div fixup).
// wide_i=1: {hi,lo} is negated as one 2W-bit number (product fixup); in
//           that mode both neg flags must be equal.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic         wide_i,
   input  logic         neg_hi_i,
   input  logic         neg_lo_i,
   input  logic [W-1:0] hi_i,
   input  logic [W-1:0] lo_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   logic         hi_carry;
   logic [W-1:0] hi_neg;
   logic [W-1:0] lo_neg;

   // A wide negate only carries into the upper word when the lower word is zero.
   always_comb begin
      hi_carry = wide_i ? (lo_i == '0) : 1'b1;
      hi_neg   = ~hi_i + {{(W-1){1'b0}}, hi_carry};
      lo_neg   = ~lo_i + {{(W-1){1'b0}}, 1'b1};
      hi_o     = neg_hi_i ? hi_neg : hi_i;
      lo_o     = neg_lo_i ? lo_neg : lo_i;
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide, one step per cycle,
// stalling the front of the pipeline until the result is committed.
// Optional macro MULDIV_EARLY_EXIT_EN: a multiply stops as soon as the
// remaining multiplier bits are zero and aligns the product in one shift.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = ITER_COUNT,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startE,
   input  logic [1:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             hi_weE,
   input  logic             lo_weE,
   input  logic [WIDTH-1:0] wdataE,
   input  logic             flushE,
   output logic             stallE,
   output logic             doneE,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   acc_q;    // product high half / partial remainder
   logic [WIDTH-1:0]   low_q;    // product low half  / dividend -> quotient
   logic [WIDTH-1:0]   opnd_q;   // |multiplicand|    / |divisor|
   logic [WIDTH-1:0]   mbits_q;  // multiplier bits not yet consumed
   logic               sign_a_q;
   logic               sign_b_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               signed_op;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               accept;
   logic               div_zero;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_acc_n;
   logic [WIDTH-1:0]   mul_low_n;
   logic [WIDTH-1:0]   mbits_n;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_last;
`ifdef MULDIV_EARLY_EXIT_EN
   logic [CNT_W-1:0]   mul_shamt;
`endif

   logic [WIDTH:0]     div_rem_s;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   div_rem_n;
   logic [WIDTH-1:0]   div_quot_n;
   logic               div_last;

   logic               is_mul;
   logic [WIDTH-1:0]   fix_hi_in;
   logic [WIDTH-1:0]   fix_lo_in;
   logic               fix_neg_hi;
   logic               fix_neg_lo;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign signed_op = op_is_signed(opE);

   // Operand magnitudes; unsigned ops pass through untouched.
   muldiv_signfix #(.W(WIDTH)) u_abs (
      .wide_i   (1'b0),
      .neg_hi_i (signed_op & srcaE[WIDTH-1]),
      .neg_lo_i (signed_op & srcbE[WIDTH-1]),
      .hi_i     (srcaE),
      .lo_i     (srcbE),
      .hi_o     (abs_a),
      .lo_o     (abs_b)
   );

   // Start handshake: a same-cycle MTHI/MTLO or a flush suppresses the start.
   always_comb begin
      accept   = (state_q == ST_IDLE) & startE & ~flushE & ~hi_weE & ~lo_weE;
      div_zero = op_is_div(opE) & (srcbE == '0);
      stallE   = accept | (state_q == ST_MUL) | (state_q == ST_DIV);
      doneE    = (state_q == ST_DONE);
      hi_o     = hi_q;
      lo_o     = lo_q;
   end

   // One shift-add multiply step and the final product alignment.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (mbits_q[0] ? {1'b0, opnd_q} : '0);
      mul_acc_n = mul_sum[WIDTH:1];
      mul_low_n = {mul_sum[0], low_q[WIDTH-1:1]};
      mbits_n   = mbits_q >> 1;
`ifdef MULDIV_EARLY_EXIT_EN
      // Remaining iterations would add nothing, only shift right.
      mul_last  = (cnt_q == LAST_ITER) | (mbits_n == '0);
      mul_shamt = LAST_ITER - cnt_q;
      mul_prod  = {mul_acc_n, mul_low_n} >> mul_shamt;
`else
      mul_last  = (cnt_q == LAST_ITER);
      mul_prod  = {mul_acc_n, mul_low_n};
`endif
   end

   // One restoring divide step.
   always_comb begin
      div_rem_s  = {acc_q, low_q[WIDTH-1]};
      div_ge     = div_rem_s >= {1'b0, opnd_q};
      div_diff   = div_rem_s[WIDTH-1:0] - opnd_q;
      div_rem_n  = div_ge ? div_diff : div_rem_s[WIDTH-1:0];
      div_quot_n = {low_q[WIDTH-2:0], div_ge};
      div_last   = (cnt_q == LAST_ITER);
   end

   // Result sign fixup: product negated as a whole, quotient by sign(a)^sign(b),
   // remainder follows the dividend.
   always_comb begin
      is_mul     = (state_q == ST_MUL);
      fix_hi_in  = is_mul ? mul_prod[2*WIDTH-1:WIDTH] : div_rem_n;
      fix_lo_in  = is_mul ? mul_prod[WIDTH-1:0]       : div_quot_n;
      fix_neg_hi = is_mul ? (sign_a_q ^ sign_b_q) : sign_a_q;
      fix_neg_lo = sign_a_q ^ sign_b_q;
   end

   muldiv_signfix #(.W(WIDTH)) u_fix (
      .wide_i   (is_mul),
      .neg_hi_i (fix_neg_hi),
      .neg_lo_i (fix_neg_lo),
      .hi_i     (fix_hi_in),
      .lo_i     (fix_lo_in),
      .hi_o     (fix_hi),
      .lo_o     (fix_lo)
   );

   // Sequencer FSM, iteration counter, datapath registers and HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         low_q    <= '0;
         opnd_q   <= '0;
         mbits_q  <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hi_weE) hi_q <= wdataE;
               if (lo_weE) lo_q <= wdataE;
               if (accept) begin
                  cnt_q    <= '0;
                  sign_a_q <= signed_op & srcaE[WIDTH-1];
                  sign_b_q <= signed_op & srcbE[WIDTH-1];
                  acc_q    <= '0;
                  if (div_zero) begin
                     hi_q    <= srcaE;
                     lo_q    <= '1;
                     state_q <= ST_DONE;
                  end else if (op_is_div(opE)) begin
                     low_q   <= abs_a;
                     opnd_q  <= abs_b;
                     state_q <= ST_DIV;
                  end else begin
                     low_q   <= '0;
                     opnd_q  <= abs_a;
                     mbits_q <= abs_b;
                     state_q <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               if (flushE) begin
                  state_q <= ST_IDLE;
               end else begin
                  acc_q   <= mul_acc_n;
                  low_q   <= mul_low_n;
                  mbits_q <= mbits_n;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  if (mul_last) begin
                     hi_q    <= fix_hi;
                     lo_q    <= fix_lo;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DIV: begin
               if (flushE) begin
                  state_q <= ST_IDLE;
               end else begin
                  acc_q <= div_rem_n;
                  low_q <= div_quot_n;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (div_last) begin
                     hi_q    <= fix_hi;
                     lo_q    <= fix_lo;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // The finished instruction is still in EX; its startE is ignored.
               if (hi_weE) hi_q <= wdataE;
               if (lo_weE) lo_q <= wdataE;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a table of operations with hand-computed
// HI/LO and stall lengths, plus sequences for MTHI/MTLO, flush and reset.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         startE;
   logic [1:0]   opE;
   logic [W-1:0] srcaE;
   logic [W-1:0] srcbE;
   logic         hi_weE;
   logic         lo_weE;
   logic [W-1:0] wdataE;
   logic         flushE;
   logic         stallE;
   logic         doneE;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .startE (startE),
      .opE    (opE),
      .srcaE  (srcaE),
      .srcbE  (srcbE),
      .hi_weE (hi_weE),
      .lo_weE (lo_weE),
      .wdataE (wdataE),
      .flushE (flushE),
      .stallE (stallE),
      .doneE  (doneE),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          stall_full;
      int          stall_early;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one op with startE held through DONE; measure the stall run.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dn, output logic dn_after, output logic st_after);
      @(negedge clk);
      startE = 1'b1; opE = op; srcaE = a; srcbE = b;
      #1;
      n = 0;
      while (stallE === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      hi = hi_o; lo = lo_o; dn = doneE;
      @(negedge clk);
      startE = 1'b0;
      #1;
      dn_after = doneE;
      st_after = stallE;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int          n;
      int          exp_stall;
      int          dcount;
      logic [31:0] hi, lo, prev_hi, prev_lo;
      logic        dn, dn_after, st_after;

      //          op        a             b             hi            lo            full early
      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 4};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
      vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1,  1};
      vecs[4]  = '{OP_MULTU, 32'd5,        32'd1,        32'h00000000, 32'h00000005, 33, 2};
      vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33, 33};
      vecs[6]  = '{OP_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 33, 3};
      vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33};
      vecs[8]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 2};
      vecs[9]  = '{OP_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 33, 2};
      vecs[10] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33, 33};

      rst = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
      hi_weE = 1'b0; lo_weE = 1'b0; wdataE = '0; flushE = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_hi", 64'(hi_o), 64'h0);
      check("reset_lo", 64'(lo_o), 64'h0);
      check("reset_stall", 64'(stallE), 64'h0);
      check("reset_done", 64'(doneE), 64'h0);
      rst = 1'b0;

      // MTHI in IDLE, then read back.
      @(negedge clk);
      hi_weE = 1'b1; wdataE = 32'h1234;
      @(negedge clk);
      hi_weE = 1'b0;
      #1;
      check("mthi_hi", 64'(hi_o), 64'h1234);
      check("mthi_lo_untouched", 64'(lo_o), 64'h0);
      $display("mthi wdata=0x1234 hi=0x%08h lo=0x%08h", hi_o, lo_o);

      // Table of arithmetic operations.
      for (int i = 0; i < NVEC; i++) begin
`ifdef MULDIV_EARLY_EXIT_EN
         exp_stall = vecs[i].stall_early;
`else
         exp_stall = vecs[i].stall_full;
`endif
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n, hi, lo, dn, dn_after, st_after);
         $display("vec %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h stall=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, n);
         check($sformatf("vec%0d_stall", i), 64'(n), 64'(exp_stall));
         check($sformatf("vec%0d_done", i), 64'(dn), 64'h1);
         check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
         check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
         check($sformatf("vec%0d_done_once", i), 64'(dn_after), 64'h0);
         check($sformatf("vec%0d_no_restart", i), 64'(st_after), 64'h0);
      end

      // Flush a divide at cycle 10: no commit, HI/LO retained.
      prev_hi = hi_o; prev_lo = lo_o;
      @(negedge clk);
      startE = 1'b1; opE = OP_DIVU; srcaE = 32'd100; srcbE = 32'd3;
      repeat (10) @(negedge clk);
      flushE = 1'b1; startE = 1'b0;
      #1;
      check("flush_c10_stall", 64'(stallE), 64'h1);
      @(negedge clk);
      flushE = 1'b0;
      #1;
      check("flush_c11_stall", 64'(stallE), 64'h0);
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (doneE === 1'b1) dcount++;
      end
      check("flush_no_done", 64'(dcount), 64'h0);
      check("flush_hi_kept", 64'(hi_o), 64'(prev_hi));
      check("flush_lo_kept", 64'(lo_o), 64'(prev_lo));
      $display("flush div at cycle 10 -> hi=0x%08h lo=0x%08h dones=%0d", hi_o, lo_o, dcount);

      // flushE in IDLE blocks a start.
      @(negedge clk);
      startE = 1'b1; flushE = 1'b1; opE = OP_MULTU; srcaE = 32'd3; srcbE = 32'd3;
      #1;
      check("idle_flush_stall", 64'(stallE), 64'h0);
      @(negedge clk);
      startE = 1'b0; flushE = 1'b0;
      #1;
      check("idle_flush_no_start", 64'(stallE), 64'h0);
      $display("idle flush with start -> stall=%0d", stallE);

      // MTLO together with start: write wins, start dropped.
      @(negedge clk);
      lo_weE = 1'b1; wdataE = 32'hCAFE; startE = 1'b1; opE = OP_MULTU;
      srcaE = 32'd3; srcbE = 32'd3;
      @(negedge clk);
      lo_weE = 1'b0; startE = 1'b0;
      #1;
      check("mtlo_start_lo", 64'(lo_o), 64'hCAFE);
      check("mtlo_start_dropped", 64'(stallE), 64'h0);
      repeat (40) @(negedge clk);
      #1;
      check("mtlo_start_lo_kept", 64'(lo_o), 64'hCAFE);
      $display("mtlo 0xCAFE with start -> lo=0x%08h", lo_o);

      // Reset in cycle 5 of a multiply.
      @(negedge clk);
      startE = 1'b1; opE = OP_MULTU; srcaE = 32'hFFFFFFFF; srcbE = 32'hFFFFFFFF;
      repeat (5) @(negedge clk);
      rst = 1'b1; startE = 1'b0;
      @(negedge clk);
      #1;
      check("midop_rst_stall", 64'(stallE), 64'h0);
      check("midop_rst_hi", 64'(hi_o), 64'h0);
      check("midop_rst_lo", 64'(lo_o), 64'h0);
      check("midop_rst_done", 64'(doneE), 64'h0);
      $display("reset at cycle 5 -> stall=%0d hi=0x%08h lo=0x%08h", stallE, hi_o, lo_o);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
